// File: rtl/max7219_spi_chain.sv
// max7219_spi_chain
//   Serial transmitter for a daisy-chain of MAX7219 LED drivers. One
//   register write per device is captured as a parallel frame and shifted
//   out MSB-first, farthest device first. SCLK is divided from clk, and the
//   block controls CS setup, hold and latch timing.
//
// Parameters
//   N_DEV    number of cascaded devices (frame F = 16*N_DEV bits)
//   CLK_DIV  SCLK half-period H in clk cycles (>= 1)
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   start    send request, sampled only while ready=1
//   address  per-device register address, byte i -> device i
//   data     per-device register data, byte i -> device i
//   ready    idle, start will be accepted
//   done     one-cycle pulse in the last cycle of the latch phase
//   sclk     serial clock, idle low
//   mosi     serial data, valid on sclk rising edge
//   cs       LOAD/CS, active-low, idle high
//
// Optional feature (macro MAX7219_SPI_CHAIN_REPEAT_EN)
//   start=1 in the final latch cycle re-captures the inputs and goes
//   straight to SETUP, skipping IDLE.

module max7219_spi_chain #(
    parameter int N_DEV   = 2,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [8*N_DEV-1:0] address,
    input  logic [8*N_DEV-1:0] data,
    output logic               ready,
    output logic               done,
    output logic               sclk,
    output logic               mosi,
    output logic               cs
);

    localparam int F      = 16 * N_DEV;
    localparam int PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW     = $clog2(F + 1);
    localparam int PH_PRE = (CLK_DIV > 1) ? CLK_DIV - 2 : 0;

    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_DONE  = PW'(PH_PRE);
    localparam logic [BW-1:0] BIT_LAST = BW'(F);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bits_q, bits_d;
    logic [F-1:0]  shreg_q, shreg_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_q, cs_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic [F-1:0]  frame;
    logic          phase_last;

    // Device N_DEV-1 occupies the top 16 bits so it is shifted out first.
    always_comb begin
        frame = '0;
        for (int unsigned i = 0; i < N_DEV; i++) begin
            frame[16*i +: 16] = {address[8*i +: 8], data[8*i +: 8]};
        end
    end

    assign phase_last = (phase_q == PH_LAST);

    always_comb begin
        state_d = state_q;
        phase_d = phase_last ? '0 : phase_q + 1'b1;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (start) begin
                    state_d = S_SETUP;
                    shreg_d = frame;
                    bits_d  = '0;
                    cs_d    = 1'b0;
                    ready_d = 1'b0;
                    mosi_d  = frame[F-1];
                end
            end
            S_SETUP: begin
                if (phase_last) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                    bits_d  = bits_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (phase_last) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        bits_d = bits_q + 1'b1;
                    end else if (bits_q == BIT_LAST) begin
                        state_d = S_HOLD;
                        sclk_d  = 1'b0;
                    end else begin
                        // Rotate rather than shift so the current bit stays at
                        // the top and the next bit is always at F-2.
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[F-2:0], shreg_q[F-1]};
                        mosi_d  = shreg_q[F-2];
                    end
                end
            end
            S_HOLD: begin
                if (phase_last) begin
                    state_d = S_LATCH;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    // With a one-cycle latch phase the first cycle is also the last.
                    done_d  = (CLK_DIV == 1);
                end
            end
            S_LATCH: begin
                if (!phase_last && (phase_q == PH_DONE)) begin
                    done_d = 1'b1;
                end
                if (phase_last) begin
`ifdef MAX7219_SPI_CHAIN_REPEAT_EN
                    if (start) begin
                        state_d = S_SETUP;
                        shreg_d = frame;
                        bits_d  = '0;
                        cs_d    = 1'b0;
                        mosi_d  = frame[F-1];
                    end else begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end
`else
                    state_d = S_IDLE;
                    ready_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                cs_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign sclk  = sclk_q;
    assign mosi  = mosi_q;
    assign cs    = cs_q;

endmodule

// File: doc/max7219_spi_chain.md
# max7219_spi_chain

Parametrised serial transmitter for a daisy-chain of MAX7219 LED drivers. It accepts one register write per device as a parallel frame. It generates a divided SCLK with controlled CS setup, hold and latch timing, then shifts the frame out MSB-first, farthest device first. It sits between the display controller FSM and the board pins and adds a ready/done handshake to the raw shift-and-send path.

## Interface
- N_DEV, 2: number of cascaded MAX7219 devices; frame length F = 16*N_DEV bits
- CLK_DIV, 4: SCLK half-period in clk cycles (H); legal range ≥ 1
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- start  in  1  request to send; sampled only while ready=1
- address  in  8*N_DEV  register address per device; byte i (bits 8i+7..8i) is for device i
- data  in  8*N_DEV  register data per device, same byte mapping
- ready  out  1  block idle, start will be accepted
- done  out  1  one-cycle pulse when a frame has been latched
- sclk  out  1  serial clock to chain, idle low
- mosi  out  1  serial data, valid on sclk rising edge
- cs  out  1  LOAD/CS to chain, active-low, idle high

## Operation
- Frame assembly at accept: the frame is the sequence {address[8N-1 -: 8], data[8N-1 -: 8]}, …, {address[7:0], data[7:0]}. It is sent MSB-first, so device N_DEV-1 (farthest) is sent first. Inputs are captured into an internal F-bit shift register. Later input changes have no effect on the current frame.
- FSM states:
  - IDLE: ready=1, cs=1, sclk=0, mosi=0. start=1 → latch frame, go to SETUP.
  - SETUP: cs=0, sclk=0, mosi=frame[F-1]. Lasts H cycles, then SHIFT.
  - SHIFT: sclk alternates H cycles high, H cycles low. mosi updates only at the high→low transition, to the next bit. After the F-th high phase, go to HOLD.
  - HOLD: sclk=0, cs=0, mosi holds the last bit. Lasts H cycles.
  - LATCH: cs=1, sclk=0, mosi=0. Lasts H cycles. done=1 in its final cycle, then IDLE.
- Counters:
  - Phase counter: $clog2(CLK_DIV) bits, wraps at H-1.
  - Bit counter: $clog2(F+1) bits, counts rising edges, terminal at F.
- ready=0 in every state except IDLE. start while busy is ignored, with no queuing (see Configuration).
- Exactly F sclk rising edges per frame. No sclk edge while cs=1.

## Timing
- All outputs are registered.
- Reset values: ready=1, done=0, cs=1, sclk=0, mosi=0, FSM=IDLE.
- Asynchronous reset mid-frame forces cs=1 and sclk=0 immediately. The partial frame is discarded without a done pulse.
- start sampled high at edge t0 (ready=1): cs=0 and ready=0 are visible after t0.
- First sclk rise at t0+H. Rising edges are every 2H cycles.
- cs low duration: (2F+1)·H cycles.
- cs high (LATCH) duration: H cycles, with done in the last one. ready=1 on the following cycle.
- Total start→ready latency: (2F+2)·H+1 cycles.
- Back-to-back: start held high is accepted again on the first IDLE cycle.
- CLK_DIV=1: sclk toggles every clk cycle. All phase lengths are 1.

## Configuration
- MAX7219_SPI_CHAIN_REPEAT_EN defined: when start=1 in the final LATCH cycle, the block re-captures address/data and goes directly to SETUP, skipping IDLE. done still pulses and ready stays 0. This gives continuous display refresh with a minimum cs-high gap of H cycles.
- Not defined: LATCH always returns to IDLE, giving at least one ready cycle between frames.

## Test plan
- Single frame: N_DEV=2, CLK_DIV=2, address=16'h0C09, data=16'h0100, start pulse. Expected response:
  - mosi sampled on sclk rises = 32'h0C01_0900, MSB first.
  - 32 rises, cs low 130 cycles, done one cycle.
  - ready back after 133 cycles.
- Reset values and idle: hold rst_n=0 then release, no start. Expected: cs=1, sclk=0, mosi=0, ready=1, done=0 throughout; no sclk edges.
- Busy rejection: start, then change address/data to 16'hFFFF and pulse start mid-frame. Expected: original bitstream unchanged and exactly one done.
- Reset mid-frame: assert rst_n=0 after the 10th sclk rise. Expected: cs=1 and sclk=0 asynchronously, no done pulse; a new frame afterwards is sent correctly.
- CLK_DIV=1, N_DEV=4: send address=32'h01020304, data=32'hAABBCCDD. Expected: stream 0x01AA_02BB_03CC_04DD, 64 rises, cs low 129 cycles.
- MAX7219_SPI_CHAIN_REPEAT_EN with start held high: expected consecutive frames with a cs-high gap of exactly H cycles, ready stays 0, and one done per frame.
